// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: exception codes, CSR numbers and the
// MEM->WB bus layout used by the mem_stage boundary.
package wb_stage_pkg;

  localparam logic [5:0] ECODE_INT     = 6'h00;
  localparam logic [5:0] ECODE_SYS     = 6'h0b;
  localparam logic [5:0] ECODE_BRK     = 6'h0c;
  localparam logic [5:0] ECODE_INE     = 6'h0d;
  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000c;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;

  // Field order here defines the bit order of the packed ms_to_ws_bus.
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        ertn;
  } ms_to_ws_t;

  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: single commit point for GPR/CSR writes, exception entry
// and ERTN return; raises the one-cycle flush and redirect PC.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        ms_csr_re,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_rvalue,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_re,
  output logic [13:0] csr_num,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        eret_flush,
  output logic        ws_flush,
  output logic [31:0] flush_pc,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic                       r_valid;
  ms_to_ws_t                  r_ms;
  logic [MS_TO_WS_BUS_WD-1:0] w_ms_to_ws_bus;
  logic                       w_int;
  logic                       w_ex_taken;

  assign w_ms_to_ws_bus = {ms_pc, ms_gr_we, ms_dest, ms_result,
                           ms_csr_re, ms_csr_we, ms_csr_num,
                           ms_csr_wmask, ms_csr_wvalue,
                           ms_ex, ms_ecode, ms_esubcode, ms_ertn};

  assign ws_allowin = 1'b1;

  // A flush squashes whatever MEM offers in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ms    <= '0;
    end else begin
      if (ws_flush)
        r_valid <= 1'b0;
      else if (ws_allowin)
        r_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin)
        r_ms <= ms_to_ws_t'(w_ms_to_ws_bus);
    end
  end

  assign w_int      = r_valid & has_int;
  assign w_ex_taken = r_valid & (r_ms.ex | has_int);

  assign wb_ex       = w_ex_taken;
  assign wb_ecode    = w_int ? ECODE_INT : r_ms.ecode;
  assign wb_esubcode = w_int ? ESUBCODE_NONE : r_ms.esubcode;
  assign wb_pc       = r_ms.pc;

  assign eret_flush = r_valid & r_ms.ertn & ~w_ex_taken;
  assign ws_flush   = wb_ex | eret_flush;
  assign flush_pc   = wb_ex ? csr_eentry : csr_era;

  // csr_we is masked on exceptions so it never coincides with wb_ex.
  assign csr_re     = r_valid & r_ms.csr_re;
  assign csr_we     = r_valid & r_ms.csr_we & ~w_ex_taken;
  assign csr_num    = r_ms.csr_num;
  assign csr_wmask  = r_ms.csr_wmask;
  assign csr_wvalue = r_ms.csr_wvalue;

  assign rf_we    = r_valid & r_ms.gr_we & ~w_ex_taken;
  assign rf_waddr = r_ms.dest;
  assign rf_wdata = csr_re ? csr_rvalue : r_ms.result;

  assign debug_wb_pc       = r_ms.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: commits, CSR access,
// exceptions, interrupt priority, ERTN and reset behaviour.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_csr_re;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_ertn;
  logic        has_int;
  logic [31:0] csr_rvalue;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        eret_flush;
  logic        ws_flush;
  logic [31:0] flush_pc;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int nChecks = 0;
  int nFails  = 0;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
    .has_int(has_int), .csr_rvalue(csr_rvalue),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .eret_flush(eret_flush), .ws_flush(ws_flush), .flush_pc(flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    ms_to_ws_valid = 1'b0;
    ms_pc          = '0;
    ms_gr_we       = 1'b0;
    ms_dest        = '0;
    ms_result      = '0;
    ms_csr_re      = 1'b0;
    ms_csr_we      = 1'b0;
    ms_csr_num     = '0;
    ms_csr_wmask   = '0;
    ms_csr_wvalue  = '0;
    ms_ex          = 1'b0;
    ms_ecode       = '0;
    ms_esubcode    = '0;
    ms_ertn        = 1'b0;
    has_int        = 1'b0;
  endtask

  // Offers one valid instruction from MEM; checks happen after the next edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic gr_we,
                               input logic [4:0] dest, input logic [31:0] result,
                               input logic cre, input logic cwe,
                               input logic [13:0] cnum, input logic ex,
                               input logic [5:0] ecode, input logic ertn);
    clearInputs();
    ms_to_ws_valid = 1'b1;
    ms_pc          = pc;
    ms_gr_we       = gr_we;
    ms_dest        = dest;
    ms_result      = result;
    ms_csr_re      = cre;
    ms_csr_we      = cwe;
    ms_csr_num     = cnum;
    ms_csr_wmask   = 32'hffff_ffff;
    ms_csr_wvalue  = 32'h0000_00aa;
    ms_ex          = ex;
    ms_ecode       = ecode;
    ms_esubcode    = 9'h000;
    ms_ertn        = ertn;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearInputs();
    stepEdge();
    stepEdge();
    nChecks++;
    if ({rf_we, csr_we, csr_re, wb_ex, eret_flush, ws_flush} !== 6'b0) begin
      nFails++;
      $display("[TB] FAIL reset_commit: got %b expected 000000",
               {rf_we, csr_we, csr_re, wb_ex, eret_flush, ws_flush});
    end
    nChecks++;
    if (debug_wb_rf_we !== 4'h0 || debug_wb_pc !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_debug: got we=%h pc=%h expected we=0 pc=0",
               debug_wb_rf_we, debug_wb_pc);
    end
    nChecks++;
    if (ws_allowin !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_allowin: got %b expected 1", ws_allowin);
    end
    reset = 1'b0;
    stepEdge();
  endtask

  task automatic test_add();
    applyStimulus(32'h1c00_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 14'h0,
                  1'b0, 6'h0, 1'b0);
    stepEdge();
    clearInputs();
    nChecks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
      nFails++;
      $display("[TB] FAIL add_rf: got we=%b addr=%0d data=%h expected we=1 addr=5 data=00001234",
               rf_we, rf_waddr, rf_wdata);
    end
    nChecks++;
    if (ws_flush !== 1'b0 || wb_ex !== 1'b0 || csr_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL add_noflush: got flush=%b ex=%b csr_we=%b expected 0 0 0",
               ws_flush, wb_ex, csr_we);
    end
    nChecks++;
    if (debug_wb_rf_we !== 4'hf || debug_wb_pc !== 32'h1c00_0000 ||
        debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h0000_1234) begin
      nFails++;
      $display("[TB] FAIL add_debug: got we=%h pc=%h num=%0d data=%h expected f 1c000000 5 00001234",
               debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    stepEdge();
    nChecks++;
    if (rf_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL add_retire: got rf_we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_csrrd();
    csr_rvalue = 32'hdead_beef;
    applyStimulus(32'h1c00_0004, 1'b1, 5'd9, 32'h0000_0777, 1'b1, 1'b0, CSR_SAVE0,
                  1'b0, 6'h0, 1'b0);
    stepEdge();
    clearInputs();
    nChecks++;
    if (csr_re !== 1'b1 || csr_num !== CSR_SAVE0 || csr_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL csrrd_port: got re=%b num=%h we=%b expected 1 0030 0",
               csr_re, csr_num, csr_we);
    end
    nChecks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hdead_beef) begin
      nFails++;
      $display("[TB] FAIL csrrd_rf: got we=%b addr=%0d data=%h expected 1 9 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_csrwr();
    applyStimulus(32'h1c00_0008, 1'b1, 5'd3, 32'h0, 1'b1, 1'b1, CSR_CRMD,
                  1'b0, 6'h0, 1'b0);
    stepEdge();
    clearInputs();
    nChecks++;
    if (csr_we !== 1'b1 || csr_wmask !== 32'hffff_ffff || csr_wvalue !== 32'h0000_00aa ||
        csr_num !== CSR_CRMD) begin
      nFails++;
      $display("[TB] FAIL csrwr_port: got we=%b mask=%h val=%h num=%h expected 1 ffffffff 000000aa 0000",
               csr_we, csr_wmask, csr_wvalue, csr_num);
    end
  endtask

  task automatic test_syscall_back_to_back();
    csr_eentry = 32'h1c00_8000;
    csr_era    = 32'h1c00_0040;
    applyStimulus(32'h1c00_0010, 1'b1, 5'd4, 32'h0000_0001, 1'b0, 1'b1, CSR_SAVE0,
                  1'b1, ECODE_SYS, 1'b0);
    stepEdge();
    // next instruction offered during the flush cycle
    applyStimulus(32'h1c00_0014, 1'b1, 5'd7, 32'h0000_0055, 1'b0, 1'b0, 14'h0,
                  1'b0, 6'h0, 1'b0);
    nChecks++;
    if (wb_ex !== 1'b1 || wb_ecode !== 6'h0b || wb_pc !== 32'h1c00_0010) begin
      nFails++;
      $display("[TB] FAIL sys_ex: got ex=%b ecode=%h pc=%h expected 1 0b 1c000010",
               wb_ex, wb_ecode, wb_pc);
    end
    nChecks++;
    if (rf_we !== 1'b0 || csr_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL sys_mask: got rf_we=%b csr_we=%b expected 0 0", rf_we, csr_we);
    end
    nChecks++;
    if (ws_flush !== 1'b1 || eret_flush !== 1'b0 || flush_pc !== 32'h1c00_8000) begin
      nFails++;
      $display("[TB] FAIL sys_flush: got flush=%b eret=%b pc=%h expected 1 0 1c008000",
               ws_flush, eret_flush, flush_pc);
    end
    stepEdge();
    clearInputs();
    nChecks++;
    if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0 || ws_flush !== 1'b0 || wb_ex !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL sys_dropped: got rf_we=%b dbg=%h flush=%b ex=%b expected 0 0 0 0",
               rf_we, debug_wb_rf_we, ws_flush, wb_ex);
    end
  endtask

  task automatic test_int_priority();
    applyStimulus(32'h1c00_0020, 1'b1, 5'd2, 32'h0, 1'b0, 1'b0, 14'h0,
                  1'b1, ECODE_SYS, 1'b0);
    ms_esubcode = 9'h005;
    stepEdge();
    clearInputs();
    has_int = 1'b1;
    #1;
    nChecks++;
    if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || wb_esubcode !== 9'h000) begin
      nFails++;
      $display("[TB] FAIL int_prio: got ex=%b ecode=%h sub=%h expected 1 00 000",
               wb_ex, wb_ecode, wb_esubcode);
    end
    has_int = 1'b0;
    #1;
    nChecks++;
    if (wb_ecode !== 6'h0b || wb_esubcode !== 9'h005) begin
      nFails++;
      $display("[TB] FAIL ex_sub: got ecode=%h sub=%h expected 0b 005", wb_ecode, wb_esubcode);
    end
    stepEdge();
  endtask

  task automatic test_int_on_plain();
    applyStimulus(32'h1c00_0024, 1'b1, 5'd6, 32'h0000_0099, 1'b0, 1'b1, CSR_SAVE0,
                  1'b0, 6'h0, 1'b0);
    stepEdge();
    clearInputs();
    has_int = 1'b1;
    #1;
    nChecks++;
    if (wb_ex !== 1'b1 || rf_we !== 1'b0 || csr_we !== 1'b0 || wb_ecode !== ECODE_INT) begin
      nFails++;
      $display("[TB] FAIL int_plain: got ex=%b rf_we=%b csr_we=%b ecode=%h expected 1 0 0 00",
               wb_ex, rf_we, csr_we, wb_ecode);
    end
    stepEdge();
    nChecks++;
    if (wb_ex !== 1'b0 || ws_flush !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL int_deferred: got ex=%b flush=%b expected 0 0", wb_ex, ws_flush);
    end
    has_int = 1'b0;
  endtask

  task automatic test_ertn();
    csr_era    = 32'h1c00_0040;
    csr_eentry = 32'h1c00_8000;
    applyStimulus(32'h1c00_0030, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 14'h0,
                  1'b0, 6'h0, 1'b1);
    stepEdge();
    clearInputs();
    nChecks++;
    if (eret_flush !== 1'b1 || wb_ex !== 1'b0 || ws_flush !== 1'b1 ||
        flush_pc !== 32'h1c00_0040) begin
      nFails++;
      $display("[TB] FAIL ertn: got eret=%b ex=%b flush=%b pc=%h expected 1 0 1 1c000040",
               eret_flush, wb_ex, ws_flush, flush_pc);
    end
    applyStimulus(32'h1c00_0034, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 14'h0,
                  1'b1, ECODE_INE, 1'b1);
    stepEdge();
    nChecks++;
    if (eret_flush !== 1'b0 || ws_flush !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL ertn_squash: got eret=%b flush=%b expected 0 0", eret_flush, ws_flush);
    end
    stepEdge();
    clearInputs();
    nChecks++;
    if (wb_ex !== 1'b1 || eret_flush !== 1'b0 || wb_ecode !== 6'h0d ||
        flush_pc !== 32'h1c00_8000) begin
      nFails++;
      $display("[TB] FAIL ertn_ex: got ex=%b eret=%b ecode=%h pc=%h expected 1 0 0d 1c008000",
               wb_ex, eret_flush, wb_ecode, flush_pc);
    end
    stepEdge();
  endtask

  task automatic test_reset_midstream();
    applyStimulus(32'h1c00_0050, 1'b1, 5'd12, 32'h0000_abcd, 1'b1, 1'b1, CSR_SAVE0,
                  1'b0, 6'h0, 1'b0);
    stepEdge();
    nChecks++;
    if (rf_we !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mid_pre: got rf_we=%b expected 1", rf_we);
    end
    reset = 1'b1;
    stepEdge();
    nChecks++;
    if ({rf_we, csr_we, csr_re, wb_ex, eret_flush, ws_flush} !== 6'b0 ||
        debug_wb_rf_we !== 4'h0 || ws_allowin !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mid_reset: got commit=%b dbg=%h allowin=%b expected 000000 0 1",
               {rf_we, csr_we, csr_re, wb_ex, eret_flush, ws_flush}, debug_wb_rf_we, ws_allowin);
    end
    nChecks++;
    if (rf_waddr !== 5'd0 || wb_pc !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL mid_cleared: got addr=%0d pc=%h expected 0 0", rf_waddr, wb_pc);
    end
    clearInputs();
    reset = 1'b0;
    stepEdge();
  endtask

  initial begin
    csr_rvalue = '0;
    csr_eentry = '0;
    csr_era    = '0;
    test_reset();
    test_add();
    test_csrrd();
    test_csrwr();
    test_syscall_back_to_back();
    test_int_priority();
    test_int_on_plain();
    test_ertn();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
